// File: rtl/icache_if.sv
// Datapath-side and memory-side handshake bundles for the instruction cache.
interface icache_dp_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  modport master (output imemREN, imemaddr, input  ihit, imemload);
  modport slave  (input  imemREN, imemaddr, output ihit, imemload);
endinterface

interface icache_mem_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (output iREN, iaddr, input  iwait, iload);
  modport slave  (input  iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache #(
  parameter int SETS = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         flush,
  icache_dp_if.slave   dp,
  icache_mem_if.master mem
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e              state_q;
  logic [29:0]         maddr_q;
  logic                iren_q;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [31:0]         data_q [SETS];

  logic [IDX_W-1:0]    idx, midx;
  logic [TAG_W-1:0]    tag, mtag;
  logic                hit, fill;
  logic [SETS-1:0]     fill_bit;

  assign idx      = dp.imemaddr[IDX_W+1:2];
  assign tag      = dp.imemaddr[31:IDX_W+2];
  assign midx     = maddr_q[IDX_W-1:0];
  assign mtag     = maddr_q[29:IDX_W];
  assign hit      = dp.imemREN & valid_q[idx] & (tag_q[idx] == tag);
  assign fill     = (state_q == FETCH) & ~mem.iwait;
  assign fill_bit = {{(SETS-1){1'b0}}, 1'b1} << midx;

  // Hits are answered in the request cycle; nothing is forwarded from a fill.
  assign dp.ihit     = (state_q == IDLE) & hit;
  assign dp.imemload = dp.ihit ? data_q[idx] : 32'h0;
  assign mem.iREN    = iren_q;
  assign mem.iaddr   = {maddr_q, 2'b00};

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      maddr_q <= '0;
      iren_q  <= 1'b0;
      valid_q <= '0;
`ifdef ICACHE_STATS_EN
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (flush) valid_q <= '0;
          if (dp.imemREN && !hit) begin
            maddr_q <= dp.imemaddr[31:2];
            iren_q  <= 1'b1;
            state_q <= FETCH;
`ifdef ICACHE_STATS_EN
            miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
          end
`ifdef ICACHE_STATS_EN
          if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
        end
        FETCH: begin
          // A flush in the fill cycle still leaves the new frame valid.
          if (fill) begin
            valid_q <= (flush ? '0 : valid_q) | fill_bit;
            iren_q  <= 1'b0;
            state_q <= IDLE;
          end else if (flush) begin
            valid_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      data_q[midx] <= mem.iload;
      tag_q[midx]  <= mtag;
    end
  end
endmodule
